a_rr_arbiter: RTL

- Round-robin arbiter that merges N valid/stall pipeline streams into one registered output stage.
- Sits where several producer stages (e.g. fetch and load-return paths) share a single downstream pipeline stage.
- Uses the same handshake as the processor pipeline stages: valid forward, stall backward, output register held while downstream stalls.
- Tags each output word with the index of the requester that supplied it.

---
 rtl/a_rr_arbiter_if.sv | 35 +++
 rtl/a_rr_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/a_rr_arbiter_if.sv
// Handshake bundle for a_rr_arbiter: N valid/stall requesters in, one registered stream out.
// A_RR_ARBITER_LOCK_EN adds the per-requester lock_i request.
interface a_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = 2
);
  logic [N-1:0]    v_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    stall_o;
  logic            v_o;
  logic [DW-1:0]   data_o;
  logic [IW-1:0]   id_o;
  logic            stall_i;
`ifdef A_RR_ARBITER_LOCK_EN
  logic [N-1:0]    lock_i;
`endif

  // slave: the arbiter itself; master: the surrounding producers/consumer
  modport slave (
    input  v_i, data_i, stall_i,
`ifdef A_RR_ARBITER_LOCK_EN
    input  lock_i,
`endif
    output stall_o, v_o, data_o, id_o
  );

  modport master (
    output v_i, data_i, stall_i,
`ifdef A_RR_ARBITER_LOCK_EN
    output lock_i,
`endif
    input  stall_o, v_o, data_o, id_o
  );
endinterface

// File: rtl/a_rr_arbiter.sv
// Round-robin merge of N valid/stall streams into one registered stage, tagged with the source index.
// Optional bus locking by a requester is enabled with macro A_RR_ARBITER_LOCK_EN.
module a_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  a_rr_arbiter_if.slave bus
);

  logic          r_v;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_id;
  logic [IW-1:0] r_ptr;

  logic          w_hold;
  logic [N-1:0]  w_lock_block;
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_gnt;
  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_data_arr [N];
  logic [DW-1:0] w_win_data;

  genvar gi;

  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_data_arr[gi] = bus.data_i[gi*DW +: DW];
    end
  endgenerate

  assign w_hold = r_v & bus.stall_i;

`ifdef A_RR_ARBITER_LOCK_EN
  logic          r_locked;
  logic [IW-1:0] r_owner;

  // While locked, everyone but the owner is blocked, whether or not the owner is requesting.
  generate
    for (gi = 0; gi < N; gi++) begin : g_lock
      assign w_lock_block[gi] = r_locked & (r_owner != IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_locked <= 1'b0;
      r_owner  <= '0;
    end else if (!w_hold && w_found) begin
      r_locked <= bus.lock_i[w_win];
      if (bus.lock_i[w_win]) begin
        r_owner <= w_win;
      end
    end
  end
`else
  assign w_lock_block = '0;
`endif

  assign w_elig = bus.v_i & ~w_lock_block;

  // Search starts just after the last winner; wrap is an explicit compare so non-power-of-two N works.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = r_ptr;
    for (int i = 0; i < N; i++) begin
      w_idx = (w_idx == IW'(N-1)) ? '0 : w_idx + IW'(1);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_stall
      assign w_gnt[gi]       = w_found & (w_win == IW'(gi));
      assign bus.stall_o[gi] = w_hold | (bus.v_i[gi] & ~w_gnt[gi]) | w_lock_block[gi];
    end
  endgenerate

  assign w_win_data = w_data_arr[w_win];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v    <= 1'b0;
      r_data <= '0;
      r_id   <= '0;
      r_ptr  <= IW'(N-1);
    end else if (!w_hold) begin
      r_v <= w_found;
      if (w_found) begin
        r_data <= w_win_data;
        r_id   <= w_win;
        r_ptr  <= w_win;
      end
    end
  end

  assign bus.v_o    = r_v;
  assign bus.data_o = r_data;
  assign bus.id_o   = r_id;

endmodule
